// File: rtl/branch_resolve_pipe_if.sv
// Handshake and result bus of the branch-resolution unit, with the two statistics counters.
interface branch_resolve_pipe_if #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned PC_W  = 32,
  parameter int unsigned CNT_W = 16
);

  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       in_cmpop;
  logic             in_is_jump;
  logic [XLEN-1:0]  in_a;
  logic [XLEN-1:0]  in_b;
  logic [PC_W-1:0]  in_pc;
  logic [PC_W-1:0]  in_target;
  logic             in_pred_taken;
  logic             out_valid;
  logic             out_ready;
  logic             out_taken;
  logic             out_mispredict;
  logic [PC_W-1:0]  out_redirect;
  logic             out_illegal;
  logic [CNT_W-1:0] cnt_resolved;
  logic [CNT_W-1:0] cnt_mispred;

  // Producer/consumer side (core pipeline or testbench)
  modport master (
    output flush, in_valid, in_cmpop, in_is_jump, in_a, in_b, in_pc, in_target,
           in_pred_taken, out_ready,
    input  in_ready, out_valid, out_taken, out_mispredict, out_redirect, out_illegal,
           cnt_resolved, cnt_mispred
  );

  // Resolution unit side
  modport slave (
    input  flush, in_valid, in_cmpop, in_is_jump, in_a, in_b, in_pc, in_target,
           in_pred_taken, out_ready,
    output in_ready, out_valid, out_taken, out_mispredict, out_redirect, out_illegal,
           cnt_resolved, cnt_mispred
  );

endinterface

// File: rtl/branch_resolve_pipe.sv
// Pipelined branch-resolution unit: evaluates B-type conditions and jumps at the input,
// carries taken/mispredict/redirect/illegal through STAGES elastic register stages,
// and keeps saturating delivered/mispredicted counters.
module branch_resolve_pipe #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned PC_W   = 32,
  parameter int unsigned STAGES = 1,
  parameter int unsigned CNT_W  = 16
) (
  input  logic                clk,
  input  logic                rst,
  branch_resolve_pipe_if.slave bus
);

  localparam int unsigned LAST = STAGES - 1;

  localparam logic [2:0] OP_BEQ  = 3'b000;
  localparam logic [2:0] OP_BNE  = 3'b001;
  localparam logic [2:0] OP_BLT  = 3'b100;
  localparam logic [2:0] OP_BGE  = 3'b101;
  localparam logic [2:0] OP_BLTU = 3'b110;
  localparam logic [2:0] OP_BGEU = 3'b111;

  logic [XLEN-1:0]  op_a;
  logic [XLEN-1:0]  op_b;
  logic [PC_W-1:0]  pc;
  logic [PC_W-1:0]  target;

  assign op_a   = bus.in_a;
  assign op_b   = bus.in_b;
  assign pc     = bus.in_pc;
  assign target = bus.in_target;

  logic             eq;
  logic             lt_s;
  logic             lt_u;
  logic             cond;
  logic             bad_op;
  logic             taken_c;
  logic             mispredict_c;
  logic             illegal_c;
  logic [PC_W-1:0]  redirect_c;

  // Condition evaluation; reserved funct3 codes resolve not-taken unless it is a jump
  always_comb begin
    eq     = (op_a == op_b);
    lt_s   = ($signed(op_a) < $signed(op_b));
    lt_u   = (op_a < op_b);
    cond   = 1'b0;
    bad_op = 1'b0;
    case (bus.in_cmpop)
      OP_BEQ:  cond = eq;
      OP_BNE:  cond = ~eq;
      OP_BLT:  cond = lt_s;
      OP_BGE:  cond = ~lt_s;
      OP_BLTU: cond = lt_u;
      OP_BGEU: cond = ~lt_u;
      default: bad_op = 1'b1;
    endcase
    taken_c      = bus.in_is_jump | cond;
    illegal_c    = bad_op & ~bus.in_is_jump;
    mispredict_c = taken_c ^ bus.in_pred_taken;
    redirect_c   = taken_c ? target : (pc + PC_W'(4));
  end

  logic [STAGES-1:0] st_valid;
  logic [STAGES-1:0] st_taken;
  logic [STAGES-1:0] st_mis;
  logic [STAGES-1:0] st_ill;
  logic [PC_W-1:0]   st_redir [STAGES];

  logic [STAGES-1:0] adv;
  logic              hole;
  logic              accept;
  logic              deliver;

  // A stage may advance if it or any stage downstream of it is empty, or the consumer is ready
  always_comb begin
    adv  = '0;
    hole = bus.out_ready;
    for (int k = int'(LAST); k >= 0; k--) begin
      hole   = hole | ~st_valid[k];
      adv[k] = hole;
    end
  end

  assign accept  = bus.in_valid & adv[0] & ~bus.flush;
  assign deliver = st_valid[LAST] & bus.out_ready;

  // Stage valid bits and payload shift; flush empties the pipe but lets payload regs idle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_valid <= '0;
      st_taken <= '0;
      st_mis   <= '0;
      st_ill   <= '0;
      for (int k = 0; k < int'(STAGES); k++) begin
        st_redir[k] <= '0;
      end
    end else begin
      if (bus.flush) begin
        st_valid <= '0;
      end else begin
        if (adv[0]) begin
          st_valid[0] <= accept;
        end
        for (int k = 1; k < int'(STAGES); k++) begin
          if (adv[k]) begin
            st_valid[k] <= st_valid[k-1];
          end
        end
      end
      if (accept) begin
        st_taken[0] <= taken_c;
        st_mis[0]   <= mispredict_c;
        st_ill[0]   <= illegal_c;
        st_redir[0] <= redirect_c;
      end
      for (int k = 1; k < int'(STAGES); k++) begin
        if (adv[k] && st_valid[k-1]) begin
          st_taken[k] <= st_taken[k-1];
          st_mis[k]   <= st_mis[k-1];
          st_ill[k]   <= st_ill[k-1];
          st_redir[k] <= st_redir[k-1];
        end
      end
    end
  end

  logic [CNT_W-1:0] cnt_res_q;
  logic [CNT_W-1:0] cnt_mis_q;

  // Saturating statistics on delivered beats; a delivery in a flush cycle still counts
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_res_q <= '0;
      cnt_mis_q <= '0;
    end else if (deliver) begin
      if (cnt_res_q != '1) begin
        cnt_res_q <= cnt_res_q + CNT_W'(1);
      end
      if (st_mis[LAST] && (cnt_mis_q != '1)) begin
        cnt_mis_q <= cnt_mis_q + CNT_W'(1);
      end
    end
  end

  assign bus.in_ready       = adv[0] | bus.flush;
  assign bus.out_valid      = st_valid[LAST];
  assign bus.out_taken      = st_taken[LAST];
  assign bus.out_mispredict = st_mis[LAST];
  assign bus.out_illegal    = st_ill[LAST];
  assign bus.out_redirect   = st_redir[LAST];
  assign bus.cnt_resolved   = cnt_res_q;
  assign bus.cnt_mispred    = cnt_mis_q;

endmodule

// File: tb/tb_branch_resolve_pipe.sv
// Directed bench: STAGES=1 instance for condition/redirect vectors, STAGES=3 CNT_W=4
// instance for streaming, stall, flush, saturation and mid-stream reset.
module tb_branch_resolve_pipe;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  branch_resolve_pipe_if #(.XLEN(32), .PC_W(32), .CNT_W(16)) bus1 ();
  branch_resolve_pipe_if #(.XLEN(32), .PC_W(32), .CNT_W(4))  bus3 ();

  branch_resolve_pipe #(.XLEN(32), .PC_W(32), .STAGES(1), .CNT_W(16)) dut1 (
    .clk(clk), .rst(rst), .bus(bus1)
  );

  branch_resolve_pipe #(.XLEN(32), .PC_W(32), .STAGES(3), .CNT_W(4)) dut3 (
    .clk(clk), .rst(rst), .bus(bus3)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%h, expected 0x%h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic [2:0]  op;
    logic        jmp;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] pc;
    logic [31:0] tgt;
    logic        pred;
    logic        taken;
    logic        mis;
    logic [31:0] redir;
    logic        ill;
  } vec_t;

  vec_t vecs [10];

  task automatic drive1(input vec_t v);
    bus1.in_cmpop      = v.op;
    bus1.in_is_jump    = v.jmp;
    bus1.in_a          = v.a;
    bus1.in_b          = v.b;
    bus1.in_pc         = v.pc;
    bus1.in_target     = v.tgt;
    bus1.in_pred_taken = v.pred;
    bus1.in_valid      = 1'b1;
  endtask

  // beq with equal operands: always taken, redirect = tgt
  task automatic drive3(input logic [31:0] tgt, input logic pred);
    bus3.in_cmpop      = 3'b000;
    bus3.in_is_jump    = 1'b0;
    bus3.in_a          = 32'h55;
    bus3.in_b          = 32'h55;
    bus3.in_pc         = 32'h4000;
    bus3.in_target     = tgt;
    bus3.in_pred_taken = pred;
    bus3.in_valid      = 1'b1;
  endtask

  int idx;
  int exp_mis;
  logic exp_v;
  logic exp_rdy;

  initial begin
    rst = 1'b1;
    {bus1.flush, bus1.in_valid, bus1.in_cmpop, bus1.in_is_jump, bus1.out_ready, bus1.in_pred_taken} = '0;
    {bus1.in_a, bus1.in_b, bus1.in_pc, bus1.in_target} = '0;
    {bus3.flush, bus3.in_valid, bus3.in_cmpop, bus3.in_is_jump, bus3.out_ready, bus3.in_pred_taken} = '0;
    {bus3.in_a, bus3.in_b, bus3.in_pc, bus3.in_target} = '0;

    //            op      jmp   a             b             pc            tgt           pred  tk    mis   redir         ill
    vecs[0] = '{3'b100, 1'b0, 32'hFFFF_FFFF, 32'h1,        32'h100,      32'h80,       1'b0, 1'b1, 1'b1, 32'h80,       1'b0};
    vecs[1] = '{3'b110, 1'b0, 32'hFFFF_FFFF, 32'h1,        32'h100,      32'h80,       1'b0, 1'b0, 1'b0, 32'h104,      1'b0};
    vecs[2] = '{3'b101, 1'b0, 32'h5,         32'h5,        32'h200,      32'h300,      1'b0, 1'b1, 1'b1, 32'h300,      1'b0};
    vecs[3] = '{3'b000, 1'b0, 32'h8000_0001, 32'h1,        32'h400,      32'h500,      1'b1, 1'b0, 1'b1, 32'h404,      1'b0};
    vecs[4] = '{3'b001, 1'b0, 32'h8000_0001, 32'h1,        32'h400,      32'h500,      1'b1, 1'b1, 1'b0, 32'h500,      1'b0};
    vecs[5] = '{3'b111, 1'b0, 32'h1,         32'hFFFF_FFFF, 32'h600,     32'h700,      1'b0, 1'b0, 1'b0, 32'h604,      1'b0};
    vecs[6] = '{3'b011, 1'b0, 32'h0,         32'h0,        32'h800,      32'h900,      1'b1, 1'b0, 1'b1, 32'h804,      1'b1};
    vecs[7] = '{3'b010, 1'b1, 32'h0,         32'h0,        32'h1000,     32'h2000,     1'b0, 1'b1, 1'b1, 32'h2000,     1'b0};
    vecs[8] = '{3'b000, 1'b0, 32'h1,         32'h2,        32'hFFFF_FFFC, 32'h40,      1'b0, 1'b0, 1'b0, 32'h0,        1'b0};
    vecs[9] = '{3'b101, 1'b0, 32'hFFFF_FFFF, 32'h1,        32'hA00,      32'hB00,      1'b0, 1'b0, 1'b0, 32'hA04,      1'b0};

    // Reset state
    @(negedge clk);
    check("rst1_valid", 32'(bus1.out_valid), 32'h0);
    check("rst1_ready", 32'(bus1.in_ready), 32'h1);
    check("rst1_redir", bus1.out_redirect, 32'h0);
    check("rst1_cnt", 32'(bus1.cnt_resolved), 32'h0);
    check("rst3_valid", 32'(bus3.out_valid), 32'h0);
    check("rst3_ready", 32'(bus3.in_ready), 32'h1);
    check("rst3_cntm", 32'(bus3.cnt_mispred), 32'h0);
    rst = 1'b0;
    @(negedge clk);

    // STAGES=1: one result per vector, one cycle after acceptance
    bus1.out_ready = 1'b1;
    exp_mis = 0;
    for (int i = 0; i < 10; i++) begin
      drive1(vecs[i]);
      if (vecs[i].mis) exp_mis++;
      @(negedge clk);
      check($sformatf("v%0d_valid", i), 32'(bus1.out_valid), 32'h1);
      check($sformatf("v%0d_taken", i), 32'(bus1.out_taken), 32'(vecs[i].taken));
      check($sformatf("v%0d_mis", i), 32'(bus1.out_mispredict), 32'(vecs[i].mis));
      check($sformatf("v%0d_redir", i), bus1.out_redirect, vecs[i].redir);
      check($sformatf("v%0d_ill", i), 32'(bus1.out_illegal), 32'(vecs[i].ill));
    end
    bus1.in_valid = 1'b0;
    @(negedge clk);
    check("s1_idle_valid", 32'(bus1.out_valid), 32'h0);
    check("s1_cnt_res", 32'(bus1.cnt_resolved), 32'd10);
    check("s1_cnt_mis", 32'(bus1.cnt_mispred), 32'(exp_mis));

    // STAGES=3: 10 back-to-back beats, first result three cycles after the first accept
    bus3.out_ready = 1'b1;
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      exp_v = (c >= 3) && (c < 13);
      check($sformatf("str_valid_c%0d", c), 32'(bus3.out_valid), 32'(exp_v));
      if (exp_v) begin
        check($sformatf("str_redir_c%0d", c), bus3.out_redirect, 32'h1000 + 32'(c - 3));
        check($sformatf("str_taken_c%0d", c), 32'(bus3.out_taken), 32'h1);
        check($sformatf("str_mis_c%0d", c), 32'(bus3.out_mispredict), 32'h0);
      end
      if (c < 10) begin
        drive3(32'h1000 + 32'(c), 1'b1);
        #1;
        check($sformatf("str_ready_c%0d", c), 32'(bus3.in_ready), 32'h1);
      end else begin
        bus3.in_valid = 1'b0;
      end
    end
    check("str_cnt_res", 32'(bus3.cnt_resolved), 32'd10);

    // Stall: consumer blocked for 5 cycles while 4 beats are offered, then released
    idx = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      exp_v = (c >= 3) && (c <= 8);
      check($sformatf("stl_valid_c%0d", c), 32'(bus3.out_valid), 32'(exp_v));
      if (exp_v) begin
        check($sformatf("stl_redir_c%0d", c), bus3.out_redirect,
              32'h2000 + ((c <= 5) ? 32'd0 : 32'(c - 5)));
      end
      bus3.out_ready = (c >= 5);
      if (idx < 4) drive3(32'h2000 + 32'(idx), 1'b1);
      else         bus3.in_valid = 1'b0;
      #1;
      exp_rdy = (c < 3) || (c >= 5);
      check($sformatf("stl_ready_c%0d", c), 32'(bus3.in_ready), 32'(exp_rdy));
      if (bus3.in_valid && exp_rdy) idx++;
    end
    check("stl_cnt_res", 32'(bus3.cnt_resolved), 32'd14);

    // Flush with two mispredicting beats in flight; the flush-cycle beat is refused
    bus3.out_ready = 1'b1;
    @(negedge clk);
    drive3(32'h3000, 1'b0);
    @(negedge clk);
    drive3(32'h3001, 1'b0);
    @(negedge clk);
    drive3(32'h3002, 1'b0);
    bus3.flush = 1'b1;
    #1;
    check("fl_ready", 32'(bus3.in_ready), 32'h1);
    @(negedge clk);
    bus3.flush    = 1'b0;
    bus3.in_valid = 1'b0;
    for (int c = 0; c < 4; c++) begin
      check($sformatf("fl_valid_c%0d", c), 32'(bus3.out_valid), 32'h0);
      @(negedge clk);
    end
    check("fl_cnt_res", 32'(bus3.cnt_resolved), 32'd14);
    check("fl_cnt_mis", 32'(bus3.cnt_mispred), 32'd0);

    // Saturation: 20 mispredicted beats into 4-bit counters
    for (int i = 0; i < 20; i++) begin
      drive3(32'h5000 + 32'(i), 1'b0);
      @(negedge clk);
    end
    bus3.in_valid = 1'b0;
    repeat (5) @(negedge clk);
    check("sat_cnt_mis", 32'(bus3.cnt_mispred), 32'd15);
    check("sat_cnt_res", 32'(bus3.cnt_resolved), 32'd15);

    // Reset in the middle of a stalled stream clears everything without a clock edge
    bus3.out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive3(32'h6000 + 32'(i), 1'b0);
      @(negedge clk);
    end
    check("mr_pre_valid", 32'(bus3.out_valid), 32'h1);
    check("mr_pre_ready", 32'(bus3.in_ready), 32'h0);
    #2;
    rst = 1'b1;
    #1;
    check("mr_valid", 32'(bus3.out_valid), 32'h0);
    check("mr_ready", 32'(bus3.in_ready), 32'h1);
    check("mr_redir", bus3.out_redirect, 32'h0);
    check("mr_taken", 32'(bus3.out_taken), 32'h0);
    check("mr_ill", 32'(bus3.out_illegal), 32'h0);
    check("mr_cnt_res", 32'(bus3.cnt_resolved), 32'h0);
    check("mr_cnt_mis", 32'(bus3.cnt_mispred), 32'h0);
    check("mr_cnt1", 32'(bus1.cnt_resolved), 32'h0);
    bus3.in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
